// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, 8N1 frame constants and bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  localparam int unsigned UART_START_BITS = 1;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_STOP_BITS  = 1;
  localparam int unsigned UART_FRAME_BITS = UART_START_BITS + UART_DATA_BITS + UART_STOP_BITS;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned uart_bit_cycles(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with wrap-bit pointers; head is presented combinationally, 0 when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = i_pop & ~o_empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = i_push & (~o_full | do_pop);
  assign o_dout  = o_empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a small RX FIFO,
// with sticky frame/overrun (and parity) error flags and a level interrupt request.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_pop,
  output logic       o_frame_err,
  output logic       o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  input  logic       i_err_clr,
  output logic       o_irq_req,
  output logic       o_busy
);

  localparam int unsigned BIT_CYCLES = uart_bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF       = BIT_CYCLES / 2;
  localparam int unsigned CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             rx_m, rx_s;
  uart_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             push, frame_set, ovr_set, par_set;
  logic             fifo_full, fifo_empty, pop_ok;

  assign pop_ok = i_rx_pop & ~fifo_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_ONE;
    idx_n     = idx;
    shreg_n   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
    ovr_set   = 1'b0;
    par_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n        = '0;
          shreg_n[idx] = rx_s;
          idx_n        = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx == 3'd7) state_n = PARITY;
`else
          if (idx == 3'd7) state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          par_set = (^shreg) != rx_s;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
            if (!fifo_full || pop_ok) push = 1'b1;
            else                      ovr_set = 1'b1;
          end else begin
            frame_set = 1'b1;
            state_n   = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= frame_set | (o_frame_err & ~i_err_clr);
      o_overrun   <= ovr_set   | (o_overrun   & ~i_err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_parity_err <= 1'b0;
    else          o_parity_err <= par_set | (o_parity_err & ~i_err_clr);
  end
  assign o_irq_req = o_rx_valid | o_frame_err | o_overrun | o_parity_err;
`else
  assign o_irq_req = o_rx_valid | o_frame_err | o_overrun | par_set;
`endif

  assign o_rx_valid = ~fifo_empty;
  assign o_busy     = (state != IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (i_rx_pop),
    .i_din   (shreg),
    .o_dout  (o_rx_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

endmodule
